// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit feeder and its FIFO.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular FIFO; pointers carry one extra bit so full and empty are distinct.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  WR_DATA,
  input  logic                   WR_EN,
  input  logic                   POP,
  output logic [DATA_WIDTH-1:0]  HEAD_DATA,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign EMPTY     = (wr_ptr == rd_ptr);
  assign FULL      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign COUNT     = wr_ptr - rd_ptr;
  assign HEAD_DATA = mem[rd_ptr[AW-1:0]];

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = WR_EN && !FULL;
  assign pop_ok  = POP && !EMPTY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= WR_DATA;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host words and hands them one at a time to a UART transmitter.
// Define UART_TX_FEEDER_OVF_EN to add the sticky OVERFLOW flag for dropped writes.
//
// state     | meaning
// IDLE      | wait for a queued word and an idle transmitter, then pop it
// SEND      | Data_Valid high for this single cycle, P_DATA holds the word
// WAIT_BUSY | wait for the transmitter to acknowledge by raising busy
// WAIT_DONE | wait for the transmitter to finish (busy low)
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  WR_DATA,
  input  logic                   WR_EN,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  input  logic                   busy,
  output logic [DATA_WIDTH-1:0]  P_DATA,
`ifdef UART_TX_FEEDER_OVF_EN
  output logic                   OVERFLOW,
`endif
  output logic                   Data_Valid
);

  feeder_state_t         state_q;
  feeder_state_t         state_d;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  dv_q;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .WR_DATA   (WR_DATA),
    .WR_EN     (WR_EN),
    .POP       (pop),
    .HEAD_DATA (head_data),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!EMPTY && !busy) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Data_Valid is a flop that mirrors state_q == SEND, so it is glitch-free.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      dv_q     <= 1'b0;
      p_data_q <= '0;
    end else begin
      state_q <= state_d;
      dv_q    <= (state_d == SEND);
      if (pop) p_data_q <= head_data;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              ovf_q <= 1'b0;
    else if (WR_EN && FULL) ovf_q <= 1'b1;
  end

  assign OVERFLOW = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple busy model of the transmitter.
module tb_uart_tx_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] WR_DATA;
  logic       WR_EN;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic       busy;
  logic [7:0] P_DATA;
  logic       Data_Valid;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       OVERFLOW;
`endif

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_DATA    (WR_DATA),
    .WR_EN      (WR_EN),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT),
    .busy       (busy),
    .P_DATA     (P_DATA),
`ifdef UART_TX_FEEDER_OVF_EN
    .OVERFLOW   (OVERFLOW),
`endif
    .Data_Valid (Data_Valid)
  );

  always #5 CLK = ~CLK;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx_q[$];
  int         busy_cnt   = 0;
  bit         force_busy = 1'b0;
  bit         dv_prev    = 1'b0;
  int         dv_double  = 0;
  int         dv_busy    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples the current cycle, advances one clock, then drives busy for the new cycle.
  // The transmitter model raises busy the cycle after Data_Valid and holds it for 10 cycles.
  task automatic tick();
    if (RST) begin
      if (Data_Valid === 1'b1) begin
        rx_q.push_back(P_DATA);
        if (busy)    dv_busy++;
        if (dv_prev) dv_double++;
        busy_cnt = 10;
      end
      dv_prev = (Data_Valid === 1'b1);
    end
    @(posedge CLK);
    #1;
    busy = force_busy || (busy_cnt != 0);
    if (busy_cnt != 0) busy_cnt--;
  endtask

  task automatic write_word(input logic [7:0] d);
    WR_DATA = d;
    WR_EN   = 1'b1;
    tick();
    WR_EN   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int pushed;
    int guard;
    logic [7:0] exp_b;

    RST = 1'b0; WR_EN = 1'b0; WR_DATA = '0; busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_dv", Data_Valid, 0);
    chk("rst_pdata", P_DATA, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("rst_ovf", OVERFLOW, 0);
`endif
    RST = 1'b1;
    drain(2);

    // single word: Data_Valid two cycles after the write
    write_word(8'hA5);
    chk("single_n1_dv", Data_Valid, 0);
    chk("single_n1_empty", EMPTY, 0);
    tick();
    chk("single_n2_dv", Data_Valid, 1);
    chk("single_n2_pdata", P_DATA, 8'hA5);
    chk("single_n2_empty", EMPTY, 1);
    wait_rx(1, 5);
    chk("single_rx", rx_q[0], 8'hA5);
    drain(15);

    // back-to-back
    base = rx_q.size();
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    wait_rx(base + 3, 100);
    chk("b2b_0", rx_q[base], 8'h11);
    chk("b2b_1", rx_q[base + 1], 8'h22);
    chk("b2b_2", rx_q[base + 2], 8'h33);
    drain(15);

    // fill with the transmitter held busy; ninth word is dropped
    base = rx_q.size();
    force_busy = 1'b1; busy = 1'b1;
    for (int i = 0; i < 9; i++) write_word(8'h40 + 8'(i));
    chk("full_full", FULL, 1);
    chk("full_count", COUNT, 8);
    chk("full_dv", Data_Valid, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("full_ovf", OVERFLOW, 1);
`endif

    // release busy and write in the pop cycle: write dropped, one word popped
    force_busy = 1'b0; busy = 1'b0;
    write_word(8'h99);
    chk("simul_count", COUNT, 7);
    chk("simul_full", FULL, 0);
    chk("simul_dv", Data_Valid, 1);
    chk("simul_pdata", P_DATA, 8'h40);
    wait_rx(base + 8, 300);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h40 + 8'(i);
      chk("full_order", rx_q[base + i], exp_b);
    end
    drain(15);
    chk("full_drained", EMPTY, 1);
    chk("full_no_extra", rx_q.size(), base + 8);

    // wrap: 20 words through an 8-deep FIFO, writing only when not full
    base = rx_q.size();
    pushed = 0;
    guard = 0;
    while (pushed < 20 && guard < 2000) begin
      if (!FULL) begin
        WR_DATA = 8'h80 + 8'(pushed);
        WR_EN   = 1'b1;
        pushed++;
      end else begin
        WR_EN = 1'b0;
      end
      tick();
      guard++;
    end
    WR_EN = 1'b0;
    chk("wrap_pushed", pushed, 20);
    wait_rx(base + 20, 400);
    for (int i = 0; i < 20; i++) begin
      exp_b = 8'h80 + 8'(i);
      chk("wrap_order", rx_q[base + i], exp_b);
    end
    drain(15);

    // reset while in WAIT_DONE with three words queued
    base = rx_q.size();
    for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
    chk("mid_sent", rx_q.size(), base + 1);
    chk("mid_count", COUNT, 3);
    RST = 1'b0;
    #2;
    chk("mid_rst_dv", Data_Valid, 0);
    chk("mid_rst_pdata", P_DATA, 0);
    chk("mid_rst_empty", EMPTY, 1);
    chk("mid_rst_full", FULL, 0);
    chk("mid_rst_count", COUNT, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("mid_rst_ovf", OVERFLOW, 0);
`endif
    busy_cnt = 0; busy = 1'b0; dv_prev = 1'b0;
    drain(2);
    RST = 1'b1;
    base = rx_q.size();
    drain(30);
    chk("mid_no_dv", rx_q.size(), base);
    chk("mid_idle_empty", EMPTY, 1);
    write_word(8'h5A);
    tick();
    chk("post_rst_dv", Data_Valid, 1);
    chk("post_rst_pdata", P_DATA, 8'h5A);
    wait_rx(base + 1, 5);
    chk("post_rst_rx", rx_q[base], 8'h5A);
    drain(15);

    chk("dv_double", dv_double, 0);
    chk("dv_while_busy", dv_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
